int_cause_unit: RTL and testbench
=================================

INT_CAUSE_UNIT -- requirements
Module: int_cause_unit

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: IRQ  in  8  device interrupt lines, level, bit 7 highest priority.
REQ-004 SHALL have ports: INT_Signal  in  1  interrupt-take request from the interrupt controller.
REQ-005 SHALL have ports: INT_PEND  in  3  vector chosen by the interrupt controller.
REQ-006 SHALL have ports: ERET  in  1  one-cycle exception-return pulse from the pipeline.
REQ-007 SHALL have ports: STATUS_WE / STATUS_WDATA  in  1/8  software STATUS write.
REQ-008 SHALL have ports: INTMASK_WE / INTMASK_WDATA  in  1/8  software mask write.
REQ-009 SHALL have ports: SCAUSE_CLR  in  8  software write-1-to-clear of pending bits.
REQ-010 SHALL have ports: STATUS, EX_SCAUSE, INTMASK  out  8 each  architectural registers.
REQ-011 SHALL have ports: INT_ACK  out  1  one-cycle take acknowledge; INT_VEC  out  3  vector in service.

Function
REQ-012 SHALL sample IRQ each cycle and set EX_SCAUSE[i] on a sampled 0->1 transition of IRQ[i]; levels alone never set a bit.
REQ-013 Without the sync option, SHALL make EX_SCAUSE[i] visible one cycle after the clock edge that first samples IRQ[i]=1.
REQ-014 SHALL use a two-state FSM: IDLE, SERVICE; reset state IDLE.
REQ-015 In IDLE with INT_Signal=1, SHALL, on the same edge: set STATUS[0] (EXL), latch INT_PEND into INT_VEC, clear EX_SCAUSE[INT_PEND], pulse INT_ACK for exactly one cycle, and enter SERVICE.
REQ-016 In SERVICE with ERET=1, SHALL clear STATUS[0] and return to IDLE; INT_VEC holds its value.
REQ-017 SHALL ignore INT_Signal in SERVICE, and SHALL ignore ERET in IDLE (no state or register change).
REQ-018 SHALL let a new IRQ edge on a bit being cleared in the same cycle (take or SCAUSE_CLR) win: the bit ends set.
REQ-019 STATUS_WE SHALL write STATUS[7:1] freely; STATUS[0] is written only if no take and no ERET happen in that cycle (hardware wins).
REQ-020 INTMASK_WE SHALL write INTMASK directly with no side effects on EX_SCAUSE.
REQ-021 SHALL register all outputs; no combinational path from any input to any output.

Reset
REQ-022 On rst_n=0, SHALL immediately force STATUS=8'h00, INTMASK=8'h00, EX_SCAUSE=8'h00, INT_ACK=0, INT_VEC=3'b000, FSM=IDLE, and all IRQ sample/sync flops=0.
REQ-023 Reset asserted in SERVICE SHALL abandon the service with no ERET required; after release, an IRQ line already high SHALL set its pending bit (0->1 relative to reset sample).

Configuration
REQ-024 Macro INT_CAUSE_SYNC_EN defined: SHALL insert a two-flop synchronizer per IRQ bit ahead of edge detection; edge-to-visible latency becomes 3 cycles.
REQ-025 Macro INT_CAUSE_SYNC_EN undefined: IRQ is assumed synchronous to clk; latency is 1 cycle per REQ-013.

Structure
REQ-026 Package int_pkg SHALL hold: FSM state enum (IDLE, SERVICE), STATUS bit indices (EXL=0, IE=1), IRQ width constant (8), and vector width (3).
REQ-027 SHALL instantiate a sub-module int_edge_sync (per-bit optional synchronizer plus rising-edge detector, 8 bits wide).

Verification
REQ-028 IRQ=8'h20 rising, no sync -> EX_SCAUSE=8'h20 one cycle later; IRQ held high 10 cycles -> no further effect.
REQ-029 EX_SCAUSE=8'h24, INT_Signal=1, INT_PEND=5 in IDLE -> next cycle STATUS[0]=1, INT_VEC=5, EX_SCAUSE=8'h04, INT_ACK high exactly 1 cycle.
REQ-030 In SERVICE, INT_Signal=1, INT_PEND=2 -> no change; then ERET -> STATUS[0]=0, FSM IDLE, INT_VEC remains 5.
REQ-031 Same cycle: take of vector 3 and new IRQ[3] edge -> EX_SCAUSE[3]=1 afterward; SCAUSE_CLR=8'h01 plus IRQ[0] edge -> bit 0 remains 1.
REQ-032 STATUS_WE with STATUS_WDATA=8'h03 in the same cycle as ERET -> STATUS=8'h02; rst_n low mid-SERVICE -> all outputs zero asynchronously.
REQ-033 With INT_CAUSE_SYNC_EN: IRQ=8'h01 rising -> EX_SCAUSE=8'h01 exactly 3 cycles later.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt cause unit.
package int_pkg;

    localparam int unsigned IrqWidth  = 8;
    localparam int unsigned VecWidth  = 3;
    localparam int unsigned StatusExl = 0;
    localparam int unsigned StatusIe  = 1;

    typedef enum logic {
        StIdle,
        StService
    } int_state_e;

endpackage

// File: rtl/int_edge_sync.sv
// Per-bit IRQ rising-edge detector. Defining INT_CAUSE_SYNC_EN inserts a two-flop
// synchronizer per bit ahead of the detector, adding two cycles of latency.
module int_edge_sync
    import int_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IrqWidth-1:0] irq_i,
    output logic [IrqWidth-1:0] rise_o
);

    logic [IrqWidth-1:0] irq_in;
    logic [IrqWidth-1:0] samp_q, samp_d;
    logic [IrqWidth-1:0] prev_q, prev_d;

`ifdef INT_CAUSE_SYNC_EN
    logic [IrqWidth-1:0] sync1_q, sync1_d;
    logic [IrqWidth-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign irq_in = sync2_q;
`else
    assign irq_in = irq_i;
`endif

    always_comb begin
        samp_d = irq_in;
        prev_d = samp_q;
    end

    // Samples reset to zero so a line already high at release counts as a rise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= '0;
            prev_q <= '0;
        end else begin
            samp_q <= samp_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = samp_q & ~prev_q;

endmodule

// File: rtl/int_cause_unit.sv
// Interrupt cause/status unit: edge-latched pending bits, take/return FSM, STATUS/INTMASK.
// Optional IRQ synchronizer enabled by defining INT_CAUSE_SYNC_EN.
module int_cause_unit
    import int_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IrqWidth-1:0] IRQ,
    input  logic                INT_Signal,
    input  logic [VecWidth-1:0] INT_PEND,
    input  logic                ERET,
    input  logic                STATUS_WE,
    input  logic [7:0]          STATUS_WDATA,
    input  logic                INTMASK_WE,
    input  logic [7:0]          INTMASK_WDATA,
    input  logic [IrqWidth-1:0] SCAUSE_CLR,
    output logic [7:0]          STATUS,
    output logic [IrqWidth-1:0] EX_SCAUSE,
    output logic [7:0]          INTMASK,
    output logic                INT_ACK,
    output logic [VecWidth-1:0] INT_VEC
);

    logic [IrqWidth-1:0] rise;
    logic [IrqWidth-1:0] clr_mask;
    logic                take;
    logic                ret;

    int_state_e          state_q, state_d;
    logic [7:0]          status_q, status_d;
    logic [7:0]          intmask_q, intmask_d;
    logic [IrqWidth-1:0] scause_q, scause_d;
    logic                ack_q, ack_d;
    logic [VecWidth-1:0] vec_q, vec_d;

    int_edge_sync u_edge_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .irq_i  (IRQ),
        .rise_o (rise)
    );

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        intmask_d = intmask_q;
        vec_d     = vec_q;
        ack_d     = 1'b0;
        take      = 1'b0;
        ret       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (INT_Signal) begin
                    take    = 1'b1;
                    state_d = StService;
                end
            end
            StService: begin
                if (ERET) begin
                    ret     = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase

        if (STATUS_WE) begin
            status_d[7:1] = STATUS_WDATA[7:1];
        end
        // Hardware take/return owns EXL over a same-cycle software write.
        if (take) begin
            status_d[StatusExl] = 1'b1;
        end else if (ret) begin
            status_d[StatusExl] = 1'b0;
        end else if (STATUS_WE) begin
            status_d[StatusExl] = STATUS_WDATA[StatusExl];
        end

        if (INTMASK_WE) begin
            intmask_d = INTMASK_WDATA;
        end

        if (take) begin
            vec_d = INT_PEND;
            ack_d = 1'b1;
        end

        // A fresh edge beats any clear landing in the same cycle.
        clr_mask = SCAUSE_CLR;
        if (take) begin
            clr_mask = clr_mask | (IrqWidth'(1) << INT_PEND);
        end
        scause_d = (scause_q & ~clr_mask) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            status_q  <= '0;
            intmask_q <= '0;
            scause_q  <= '0;
            ack_q     <= 1'b0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            intmask_q <= intmask_d;
            scause_q  <= scause_d;
            ack_q     <= ack_d;
            vec_q     <= vec_d;
        end
    end

    assign STATUS    = status_q;
    assign EX_SCAUSE = scause_q;
    assign INTMASK   = intmask_q;
    assign INT_ACK   = ack_q;
    assign INT_VEC   = vec_q;

endmodule

// File: tb/tb_int_cause_unit.sv
// Self-checking bench for int_cause_unit: directed vector table, reset sequence, and
// randomized traffic compared against a cycle-level reference model.
module tb_int_cause_unit;

`ifdef INT_CAUSE_SYNC_EN
    localparam int Lat = 3;
`else
    localparam int Lat = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] IRQ;
    logic       INT_Signal;
    logic [2:0] INT_PEND;
    logic       ERET;
    logic       STATUS_WE;
    logic [7:0] STATUS_WDATA;
    logic       INTMASK_WE;
    logic [7:0] INTMASK_WDATA;
    logic [7:0] SCAUSE_CLR;
    logic [7:0] STATUS;
    logic [7:0] EX_SCAUSE;
    logic [7:0] INTMASK;
    logic       INT_ACK;
    logic [2:0] INT_VEC;

    int checks = 0;
    int errors = 0;

    int_cause_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .IRQ           (IRQ),
        .INT_Signal    (INT_Signal),
        .INT_PEND      (INT_PEND),
        .ERET          (ERET),
        .STATUS_WE     (STATUS_WE),
        .STATUS_WDATA  (STATUS_WDATA),
        .INTMASK_WE    (INTMASK_WE),
        .INTMASK_WDATA (INTMASK_WDATA),
        .SCAUSE_CLR    (SCAUSE_CLR),
        .STATUS        (STATUS),
        .EX_SCAUSE     (EX_SCAUSE),
        .INTMASK       (INTMASK),
        .INT_ACK       (INT_ACK),
        .INT_VEC       (INT_VEC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic       isig;
        logic [2:0] pend;
        logic       eret;
        logic       swe;
        logic [7:0] swd;
        logic       mwe;
        logic [7:0] mwd;
        logic [7:0] clr;
        logic [7:0] e_status;
        logic [7:0] e_scause;
        logic [7:0] e_mask;
        logic       e_ack;
        logic [2:0] e_vec;
    } vec_t;

    // Reference model: architectural state plus history of IRQ samples since reset.
    logic [7:0] m_status, m_mask, m_scause;
    logic       m_ack, m_busy;
    logic [2:0] m_vec;
    logic [7:0] hist[$];

    function automatic vec_t mk(logic [7:0] irq, logic isig, logic [2:0] pend, logic eret,
                                logic swe, logic [7:0] swd, logic mwe, logic [7:0] mwd,
                                logic [7:0] clr, logic [7:0] es, logic [7:0] ec,
                                logic [7:0] em, logic ea, logic [2:0] ev);
        vec_t v;
        v.irq = irq; v.isig = isig; v.pend = pend; v.eret = eret;
        v.swe = swe; v.swd = swd; v.mwe = mwe; v.mwd = mwd; v.clr = clr;
        v.e_status = es; v.e_scause = ec; v.e_mask = em; v.e_ack = ea; v.e_vec = ev;
        return v;
    endfunction

    function automatic logic [7:0] hist_at(int idx);
        if (idx >= 0 && idx < hist.size()) return hist[idx];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = 8'h00; m_mask = 8'h00; m_scause = 8'h00;
        m_ack = 1'b0; m_busy = 1'b0; m_vec = 3'd0;
        hist.delete();
    endtask

    task automatic model_edge();
        int n;
        logic [7:0] rise, clr;
        logic take, ret;
        n    = hist.size();
        // A rise sampled at edge k becomes pending at edge k+Lat.
        rise = hist_at(n - Lat) & ~hist_at(n - Lat - 1);
        hist.push_back(IRQ);
        if (hist.size() > 8) void'(hist.pop_front());
        take = !m_busy && INT_Signal;
        ret  = m_busy && ERET;
        clr  = SCAUSE_CLR;
        if (take) clr[INT_PEND] = 1'b1;
        m_scause = (m_scause & ~clr) | rise;
        if (STATUS_WE) m_status[7:1] = STATUS_WDATA[7:1];
        if (take) m_status[0] = 1'b1;
        else if (ret) m_status[0] = 1'b0;
        else if (STATUS_WE) m_status[0] = STATUS_WDATA[0];
        if (INTMASK_WE) m_mask = INTMASK_WDATA;
        m_ack = take;
        if (take) m_vec = INT_PEND;
        if (take) m_busy = 1'b1;
        else if (ret) m_busy = 1'b0;
    endtask

    task automatic check_model();
        chk("model_status", STATUS, m_status);
        chk("model_scause", EX_SCAUSE, m_scause);
        chk("model_mask", INTMASK, m_mask);
        chk("model_ack", {7'd0, INT_ACK}, {7'd0, m_ack});
        chk("model_vec", {5'd0, INT_VEC}, {5'd0, m_vec});
    endtask

    // Called just after a negedge: drive, take the posedge, compare at the next negedge.
    task automatic step(input vec_t v, input bit use_tbl, input int row);
        IRQ = v.irq; INT_Signal = v.isig; INT_PEND = v.pend; ERET = v.eret;
        STATUS_WE = v.swe; STATUS_WDATA = v.swd; INTMASK_WE = v.mwe;
        INTMASK_WDATA = v.mwd; SCAUSE_CLR = v.clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
        if (use_tbl) begin
            chk($sformatf("tbl%0d_status", row), STATUS, v.e_status);
            chk($sformatf("tbl%0d_scause", row), EX_SCAUSE, v.e_scause);
            chk($sformatf("tbl%0d_mask", row), INTMASK, v.e_mask);
            chk($sformatf("tbl%0d_ack", row), {7'd0, INT_ACK}, {7'd0, v.e_ack});
            chk($sformatf("tbl%0d_vec", row), {5'd0, INT_VEC}, {5'd0, v.e_vec});
        end
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        IRQ = 8'h00; INT_Signal = 1'b0; INT_PEND = 3'd0; ERET = 1'b0;
        STATUS_WE = 1'b0; STATUS_WDATA = 8'h00; INTMASK_WE = 1'b0;
        INTMASK_WDATA = 8'h00; SCAUSE_CLR = 8'h00;
        model_reset();

`ifndef INT_CAUSE_SYNC_EN
        //            irq  sig pnd ert swe swd  mwe mwd  clr    status scause mask ack vec
        tbl.push_back(mk(8'h20, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(8'h20, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0));
        tbl.push_back(mk(8'h24, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 0, 0));
        tbl.push_back(mk(8'h24, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 0, 0));
        tbl.push_back(mk(8'h24, 1, 5, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h04, 8'h00, 1, 5));
        tbl.push_back(mk(8'h24, 1, 2, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h04, 8'h00, 0, 5));
        tbl.push_back(mk(8'h24, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 0, 5));
        tbl.push_back(mk(8'h24, 0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 0, 5));
        tbl.push_back(mk(8'h2c, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 0, 5));
        tbl.push_back(mk(8'h2c, 1, 3, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h0c, 8'h00, 1, 3));
        tbl.push_back(mk(8'h2c, 0, 0, 1, 1, 8'h03, 0, 8'h00, 8'h00, 8'h02, 8'h0c, 8'h00, 0, 3));
        tbl.push_back(mk(8'h2d, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h02, 8'h0c, 8'h00, 0, 3));
        tbl.push_back(mk(8'h2d, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h05, 8'h02, 8'h09, 8'h00, 0, 3));
        tbl.push_back(mk(8'h2d, 0, 0, 0, 1, 8'hf0, 1, 8'ha5, 8'h00, 8'hf0, 8'h09, 8'ha5, 0, 3));
        tbl.push_back(mk(8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'hff, 8'hf0, 8'h00, 8'ha5, 0, 3));
        tbl.push_back(mk(8'h00, 0, 0, 0, 1, 8'h01, 0, 8'h00, 8'h00, 8'h01, 8'h00, 8'ha5, 0, 3));
        tbl.push_back(mk(8'h00, 1, 0, 0, 1, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h00, 8'ha5, 1, 0));
`else
        tbl.push_back(mk(8'h01, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 0, 0));
        tbl.push_back(mk(8'h01, 1, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1, 0));
`endif

        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, i);

        // Hold the line high: no further pending activity.
        rv = mk(8'h24, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(rv, 1'b0, 0);

        // Ensure we are in service, then reset asynchronously mid-cycle.
        rv = mk(8'h81, 1, 6, 0, 0, 8'h00, 1, 8'h3c, 8'h00, 0, 0, 0, 0, 0);
        step(rv, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_status", STATUS, 8'h00);
        chk("arst_scause", EX_SCAUSE, 8'h00);
        chk("arst_mask", INTMASK, 8'h00);
        chk("arst_ack", {7'd0, INT_ACK}, 8'h00);
        chk("arst_vec", {5'd0, INT_VEC}, 8'h00);
        model_reset();
        INT_Signal = 1'b0;
        INTMASK_WE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Line already high across reset must register as a fresh edge.
        rv = mk(8'h81, 0, 0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i <= Lat; i++) step(rv, 1'b0, 0);
        chk("post_rst_pending", EX_SCAUSE, 8'h81);
        rv.isig = 1'b1; rv.pend = 3'd7;
        step(rv, 1'b0, 0);
        chk("post_rst_take_ack", {7'd0, INT_ACK}, 8'h01);

        for (int i = 0; i < 400; i++) begin
            rv.irq  = 8'($urandom);
            rv.isig = ($urandom_range(0, 3) == 0);
            rv.pend = 3'($urandom);
            rv.eret = ($urandom_range(0, 3) == 0);
            rv.swe  = ($urandom_range(0, 5) == 0);
            rv.swd  = 8'($urandom);
            rv.mwe  = ($urandom_range(0, 5) == 0);
            rv.mwd  = 8'($urandom);
            rv.clr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(rv, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
